// File: rtl/axi4_burst_ram.sv
// AXI4 burst RAM slave: FIXED/INCR/WRAP bursts, narrow transfers, byte strobes, SLVERR on bad requests.
// Valid/ready: a beat transfers on the rising aclk edge where valid && ready; valid never drops without it.
module axi4_burst_ram #(
    parameter int DATA_W     = 32,
    parameter int AXI_ADDR_W = 32,
    parameter int MEM_ADDR_W = 12,
    parameter int ID_W       = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // write address
    input  logic [ID_W-1:0]       awid,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    // write data
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    // write response
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    // read address
    input  logic [ID_W-1:0]       arid,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    // read data
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    // FSM state observation
    output logic [1:0]            w_state_dbg,
    output logic                  r_state_dbg
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = MEM_ADDR_W - LSB;
    localparam int WORDS  = 1 << IDX_W;
    localparam int BLK_W  = MEM_ADDR_W + 9;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic addr_err(
        input logic [AXI_ADDR_W-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [MEM_ADDR_W-1:0] low_mask;
        logic                  bad;
        low_mask = (MEM_ADDR_W'(1) << size) - MEM_ADDR_W'(1);
        bad      = 1'b0;
        if ((a >> MEM_ADDR_W) != '0) bad = 1'b1;
        if (burst == 2'b11)          bad = 1'b1;
        if (size > 3'(LSB))          bad = 1'b1;
        if (burst == BURST_WRAP) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) bad = 1'b1;
            if ((a[MEM_ADDR_W-1:0] & low_mask) != '0) bad = 1'b1;
        end
        return bad;
    endfunction

    // Address of the beat after 'a'; INCR realigns after beat 0, WRAP stays inside its block.
    function automatic logic [MEM_ADDR_W-1:0] next_addr(
        input logic [MEM_ADDR_W-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [MEM_ADDR_W-1:0] step;
        logic [MEM_ADDR_W-1:0] wmask;
        logic [MEM_ADDR_W-1:0] res;
        logic [BLK_W-1:0]      blk;
        step  = MEM_ADDR_W'(1) << size;
        blk   = (BLK_W'(len) + BLK_W'(1)) << size;
        wmask = MEM_ADDR_W'(blk - BLK_W'(1));
        case (burst)
            BURST_FIXED: res = a;
            BURST_WRAP:  res = (a & ~wmask) | ((a + step) & wmask);
            default:     res = (a & ~(step - MEM_ADDR_W'(1))) + step;
        endcase
        return res;
    endfunction

    logic [DATA_W-1:0] mem [WORDS];

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [MEM_ADDR_W-1:0] w_addr;
    logic [MEM_ADDR_W-1:0] w_nxt;
    logic [7:0]            w_len;
    logic [7:0]            w_beat;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err;
    logic                  w_last_err;
    logic                  aw_err;
    logic                  aw_hs, w_hs, b_hs;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign b_hs        = bvalid && bready;
    assign wready      = (w_state == W_DATA);
    assign bvalid      = (w_state == W_RESP);
    assign w_state_dbg = w_state;

    always_comb begin
        w_next = w_state;
        aw_err = addr_err(awaddr, awlen, awsize, awburst);
        w_nxt  = next_addr(w_addr, w_len, w_size, w_burst);
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && (w_beat == w_len)) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state    <= W_IDLE;
            awready    <= 1'b0;
            bid        <= '0;
            bresp      <= RESP_OKAY;
            w_addr     <= '0;
            w_len      <= '0;
            w_beat     <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_err      <= 1'b0;
            w_last_err <= 1'b0;
        end else begin
            w_state <= w_next;
            awready <= (w_next == W_IDLE);
            if (aw_hs) begin
                bid        <= awid;
                w_addr     <= awaddr[MEM_ADDR_W-1:0];
                w_len      <= awlen;
                w_size     <= awsize;
                w_burst    <= awburst;
                w_err      <= aw_err;
                w_beat     <= '0;
                w_last_err <= 1'b0;
            end
            if (w_hs) begin
                w_beat <= w_beat + 8'd1;
                w_addr <= w_nxt;
                if (wlast != (w_beat == w_len)) w_last_err <= 1'b1;
                // On the final beat wlast must be high, so a low wlast here is itself an error.
                if (w_beat == w_len)
                    bresp <= (w_err || w_last_err || !wlast) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[w_addr[MEM_ADDR_W-1:LSB]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [MEM_ADDR_W-1:0] r_nxt;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic                  ar_err;
    logic                  ar_hs, r_hs;

    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign rvalid      = (r_state == R_DATA);
    assign r_state_dbg = r_state;

    always_comb begin
        r_next = r_state;
        ar_err = addr_err(araddr, arlen, arsize, arburst);
        r_nxt  = next_addr(r_addr, r_len, r_size, r_burst);
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // rdata samples the array before any same-edge write lands, giving read-before-write.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            if (ar_hs) begin
                rid     <= arid;
                r_addr  <= araddr[MEM_ADDR_W-1:0];
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_err   <= ar_err;
                r_beat  <= '0;
                rlast   <= (arlen == 8'd0);
                rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                rdata   <= ar_err ? '0 : mem[araddr[MEM_ADDR_W-1:LSB]];
            end else if (r_hs && !rlast) begin
                r_addr <= r_nxt;
                r_beat <= r_beat + 8'd1;
                rlast  <= ((r_beat + 8'd1) == r_len);
                rdata  <= r_err ? '0 : mem[r_nxt[MEM_ADDR_W-1:LSB]];
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_ram.sv
// Bench for axi4_burst_ram: directed vector table, hand sequences for timing corners,
// and randomized bursts checked against a byte-array memory model.
module tb_axi4_burst_ram;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [1:0]  w_state_dbg;
    logic        r_state_dbg;

    axi4_burst_ram #(
        .DATA_W(32), .AXI_ADDR_W(32), .MEM_ADDR_W(12), .ID_W(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  ref_mem [4096];
    logic [31:0] wd_buf  [256];
    logic [3:0]  ws_buf  [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];

    typedef struct {
        bit          is_read;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          bad_last;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [14];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_err(input logic [31:0] a, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        int sz;
        sz = 1 << size;
        if (a >= 32'd4096) return 1'b1;
        if (burst == 2'b11) return 1'b1;
        if (sz > 4) return 1'b1;
        if (burst == WRAP) begin
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
            if ((int'(a) % sz) != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int m_beat_addr(input int start, input int len, input int size,
                                       input logic [1:0] burst, input int n);
        int sz, blk, base;
        sz = 1 << size;
        if (burst == FIXED) return start;
        if (burst == INCR) return (n == 0) ? start : ((start / sz) * sz + n * sz) % 4096;
        blk  = (len + 1) * sz;
        base = (start / blk) * blk;
        return base + ((start - base) + n * sz) % blk;
    endfunction

    function automatic logic [31:0] m_word(input int a);
        int w;
        w = a - (a % 4);
        return {ref_mem[w + 3], ref_mem[w + 2], ref_mem[w + 1], ref_mem[w]};
    endfunction

    task automatic m_write_beat(input int a, input logic [31:0] d, input logic [3:0] s);
        int w;
        w = a - (a % 4);
        for (int l = 0; l < 4; l++) if (s[l]) ref_mem[w + l] = d[8*l +: 8];
    endtask

    // ---------------- drivers ----------------
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                            input bit stall, output logic [1:0] resp, output logic [3:0] rbid);
        int cyc;
        bit seen_stall, done;
        logic [5:0] saved;
        resp = 2'b11;
        rbid = '0;
        saved = '0;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 200) begin @(negedge aclk); cyc++; end
        check("aw_ready_wait", awready, 1'b1);
        @(negedge aclk);
        awvalid = 1'b0;
        check("aw_to_wready", {awready, wready}, 2'b01);
        for (int n = 0; n <= int'(len); n++) begin
            if (stall) while ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
            wdata = wd_buf[n];
            wstrb = ws_buf[n];
            wlast = (bad_last >= 0) ? (n == bad_last) : (n == int'(len));
            wvalid = 1'b1;
            cyc = 0;
            while (!wready && cyc < 200) begin @(negedge aclk); cyc++; end
            if (!wready) check("w_ready_wait", wready, 1'b1);
            @(negedge aclk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("w_to_bvalid", {wready, bvalid}, 2'b01);
        seen_stall = 0; done = 0; cyc = 0;
        while (!done && cyc < 200) begin
            if (!bvalid) begin
                check("b_valid_hold", bvalid, 1'b1);
                break;
            end
            if (seen_stall) check("b_hold", {bid, bresp}, saved);
            bready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bready) begin
                resp = bresp; rbid = bid; done = 1;
            end else begin
                seen_stall = 1; saved = {bid, bresp};
            end
            @(negedge aclk);
            cyc++;
        end
        bready = 1'b0;
        check("b_done", done, 1'b1);
        check("b_to_awready", {awready, bvalid}, 2'b10);
        if (!m_err(addr, len, size, burst))
            for (int n = 0; n <= int'(len); n++)
                m_write_beat(m_beat_addr(int'(addr), int'(len), int'(size), burst, n), wd_buf[n], ws_buf[n]);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int cyc, beat;
        bit prev_stall;
        logic [38:0] saved;
        saved = '0;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 200) begin @(negedge aclk); cyc++; end
        check("ar_ready_wait", arready, 1'b1);
        @(negedge aclk);
        arvalid = 1'b0;
        check("ar_to_rvalid", {arready, rvalid}, 2'b01);
        beat = 0; cyc = 0; prev_stall = 0;
        while (beat <= int'(len) && cyc < 2000) begin
            if (!rvalid) begin
                check("r_valid_hold", rvalid, 1'b1);
                break;
            end
            if (prev_stall) check("r_hold", {rdata, rresp, rlast, rid}, saved);
            rready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rready) begin
                rd_data[beat] = rdata;
                rd_resp[beat] = rresp;
                check("r_last", rlast, (beat == int'(len)));
                check("r_id", rid, id);
                beat++;
                prev_stall = 0;
            end else begin
                prev_stall = 1;
                saved = {rdata, rresp, rlast, rid};
            end
            @(negedge aclk);
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", beat, int'(len) + 1);
        check("r_to_arready", {arready, rvalid}, 2'b10);
    endtask

    task automatic read_check(input string name, input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input bit stall, input logic [1:0] exp_resp);
        logic [31:0] exp;
        do_read(id, addr, len, size, burst, stall);
        for (int n = 0; n <= int'(len); n++) begin
            exp = (exp_resp == SLVERR) ? 32'h0 :
                  m_word(m_beat_addr(int'(addr), int'(len), int'(size), burst, n));
            check({name, "_data"}, rd_data[n], exp);
            check({name, "_resp"}, rd_resp[n], exp_resp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rresp, rid,
                     rdata, w_state_dbg, r_state_dbg}, '0);
    endtask

    initial begin
        #800000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  rb;
        logic [31:0] exp_wrap [4];
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          bad_last;
        bit          stall, err;

        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset and release timing.
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset_outputs");
        aresetn = 1'b1;
        #1 check("ready_before_edge", {awready, arready}, 2'b00);
        @(posedge aclk);
        #1 check("ready_after_edge", {awready, arready}, 2'b11);

        // Preload the whole memory with random words so every later read is predictable.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 256; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hf; end
            do_write(4'd0, 32'(c * 1024), 8'd255, 3'd2, INCR, -1, 1'b0, resp, rb);
            check("preload_bresp", resp, OKAY);
        end

        // INCR write then back-to-back read.
        wd_buf[0] = 32'hdeadbeef; wd_buf[1] = 32'hc0decafe; wd_buf[2] = 32'hbabeb00b;
        for (int i = 0; i < 3; i++) ws_buf[i] = 4'hf;
        do_write(4'h5, 32'h100, 8'd2, 3'd2, INCR, -1, 1'b0, resp, rb);
        check("incr_bresp", resp, OKAY);
        check("incr_bid", rb, 4'h5);
        do_read(4'hA, 32'h100, 8'd2, 3'd2, INCR, 1'b0);
        check("incr_rd0", rd_data[0], 32'hdeadbeef);
        check("incr_rd1", rd_data[1], 32'hc0decafe);
        check("incr_rd2", rd_data[2], 32'hbabeb00b);
        check("incr_rresp", {rd_resp[0], rd_resp[1], rd_resp[2]}, 6'b0);

        // WRAP read order.
        for (int i = 0; i < 8; i++) begin wd_buf[i] = 32'h100 + 32'(4 * i); ws_buf[i] = 4'hf; end
        do_write(4'h1, 32'h100, 8'd7, 3'd2, INCR, -1, 1'b0, resp, rb);
        do_read(4'h2, 32'h10C, 8'd3, 3'd2, WRAP, 1'b0);
        exp_wrap[0] = 32'h10C; exp_wrap[1] = 32'h100; exp_wrap[2] = 32'h104; exp_wrap[3] = 32'h108;
        for (int i = 0; i < 4; i++) check("wrap_order", rd_data[i], exp_wrap[i]);

        // Narrow FIXED write with strobes.
        wd_buf[0] = 32'h0; ws_buf[0] = 4'hf;
        do_write(4'h3, 32'h200, 8'd0, 3'd2, INCR, -1, 1'b0, resp, rb);
        wd_buf[0] = 32'h0000_00AA; ws_buf[0] = 4'b0001;
        wd_buf[1] = 32'h0000_BB00; ws_buf[1] = 4'b0010;
        do_write(4'h3, 32'h200, 8'd1, 3'd0, FIXED, -1, 1'b0, resp, rb);
        check("narrow_bresp", resp, OKAY);
        do_read(4'h3, 32'h200, 8'd0, 3'd2, INCR, 1'b0);
        check("narrow_word", rd_data[0], 32'h0000BBAA);

        // Directed vector table.
        vecs[0]  = '{1'b0, 32'h0000_1000, 8'd0, 3'd2, INCR,  -1, SLVERR};
        vecs[1]  = '{1'b1, 32'h0000_0000, 8'd0, 3'd2, INCR,  -1, OKAY};
        vecs[2]  = '{1'b0, 32'h0000_0100, 8'd2, 3'd2, WRAP,  -1, SLVERR};
        vecs[3]  = '{1'b1, 32'h0000_0100, 8'd1, 3'd2, 2'b11, -1, SLVERR};
        vecs[4]  = '{1'b0, 32'h0000_0400, 8'd3, 3'd2, INCR,   1, SLVERR};
        vecs[5]  = '{1'b1, 32'h0000_0400, 8'd3, 3'd2, INCR,  -1, OKAY};
        vecs[6]  = '{1'b0, 32'h0000_0404, 8'd0, 3'd3, INCR,  -1, SLVERR};
        vecs[7]  = '{1'b0, 32'h0000_0102, 8'd3, 3'd2, WRAP,  -1, SLVERR};
        vecs[8]  = '{1'b0, 32'h0000_07F0, 8'd3, 3'd2, WRAP,  -1, OKAY};
        vecs[9]  = '{1'b1, 32'h0000_07F8, 8'd3, 3'd2, WRAP,  -1, OKAY};
        vecs[10] = '{1'b1, 32'h2000_0000, 8'd2, 3'd2, INCR,  -1, SLVERR};
        vecs[11] = '{1'b0, 32'h0000_0FFC, 8'd1, 3'd2, INCR,  -1, OKAY};
        vecs[12] = '{1'b1, 32'h0000_0FFC, 8'd1, 3'd2, INCR,  -1, OKAY};
        vecs[13] = '{1'b1, 32'h0000_07F1, 8'd2, 3'd0, INCR,  -1, OKAY};
        for (int v = 0; v < 14; v++) begin
            id = 4'(v);
            if (vecs[v].is_read) begin
                read_check("vec_read", id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                           v[0], vecs[v].exp_resp);
            end else begin
                for (int i = 0; i <= int'(vecs[v].len); i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hf; end
                do_write(id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].bad_last,
                         v[0], resp, rb);
                check("vec_bresp", resp, vecs[v].exp_resp);
                check("vec_bid", rb, id);
            end
        end

        // Same-edge AW and AR to one word: the read sees the old data.
        wd_buf[0] = 32'h1111_1111; ws_buf[0] = 4'hf;
        do_write(4'h4, 32'h300, 8'd0, 3'd2, INCR, -1, 1'b0, resp, rb);
        wd_buf[0] = 32'h2222_2222;
        fork
            do_write(4'h6, 32'h300, 8'd0, 3'd2, INCR, -1, 1'b0, resp, rb);
            do_read(4'h7, 32'h300, 8'd0, 3'd2, INCR, 1'b0);
        join
        check("collision_old", rd_data[0], 32'h1111_1111);
        do_read(4'h7, 32'h300, 8'd0, 3'd2, INCR, 1'b0);
        check("collision_new", rd_data[0], 32'h2222_2222);

        // Randomized bursts against the model.
        for (int t = 0; t < 40; t++) begin
            int r;
            id = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            burst = (r < 2) ? FIXED : (r < 6) ? INCR : (r < 9) ? WRAP : 2'b11;
            size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (burst == WRAP && $urandom_range(0, 9) != 0) begin
                r = $urandom_range(0, 3);
                len = 8'((2 << r) - 1);
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            addr = 32'($urandom_range(0, 4095));
            if (burst == WRAP && size < 3 && $urandom_range(0, 9) != 0) addr = addr & ~((32'd1 << size) - 1);
            if ($urandom_range(0, 11) == 0) addr = addr | 32'h0001_0000;
            stall = ($urandom_range(0, 1) == 1);
            err = m_err(addr, len, size, burst);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wd_buf[i] = $urandom;
                    ws_buf[i] = 4'($urandom_range(0, 15));
                end
                bad_last = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : -1;
                do_write(id, addr, len, size, burst, bad_last, stall, resp, rb);
                check("rand_bresp", resp,
                      (err || (bad_last >= 0 && bad_last != int'(len))) ? SLVERR : OKAY);
                check("rand_bid", rb, id);
            end else begin
                read_check("rand_read", id, addr, len, size, burst, stall, err ? SLVERR : OKAY);
            end
        end

        // Reset during beat 2 of a 4-beat write.
        for (int i = 0; i < 4; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hf; end
        @(negedge aclk);
        awid = 4'h9; awaddr = 32'h500; awlen = 8'd3; awsize = 3'd2; awburst = INCR; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            wdata = wd_buf[n]; wstrb = 4'hf; wlast = 1'b0; wvalid = 1'b1;
            check("rst_burst_wready", wready, 1'b1);
            @(negedge aclk);
            m_write_beat(32'h500 + 4 * n, wd_buf[n], 4'hf);
        end
        wdata = wd_buf[2];
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("midburst_reset_outputs");
        wvalid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        #1 check("rst2_ready_before_edge", {awready, arready}, 2'b00);
        @(posedge aclk);
        #1 check("rst2_ready_after_edge", {awready, arready}, 2'b11);
        read_check("after_reset_partial", 4'h9, 32'h500, 8'd3, 3'd2, INCR, 1'b0, OKAY);
        for (int i = 0; i < 2; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hf; end
        do_write(4'hB, 32'h600, 8'd1, 3'd2, INCR, -1, 1'b0, resp, rb);
        check("after_reset_bresp", resp, OKAY);
        read_check("after_reset_read", 4'hC, 32'h600, 8'd1, 3'd2, INCR, 1'b0, OKAY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
